hdmi_tx_video_guard: RTL and testbench

Pixel-domain stage between the HDMI transmit formatter and the ADV7513 pins.
- Takes the formatter's parallel video (DE, active-low HSYNC/VSYNC, 8-bit RGB) and checks every frame against the expected 1280x720 active geometry.
- While the stream is not locked, or when the pattern is forced, it replaces the pixel data with 8 vertical colour bars aligned to the incoming syncs.
- The display therefore never shows a torn or garbage frame after reset or after upstream FIFO underrun.

---
 rtl/hdmi_video_pkg.sv | 27 ++
 rtl/hdmi_colorbar_gen.sv | 74 +++++++
 rtl/hdmi_tx_video_guard.sv | 262 ++++++++++++++++++++++++++
 tb/tb_hdmi_tx_video_guard.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/hdmi_video_pkg.sv
// -----------------------------------------------------------------------------
// hdmi_video_pkg
// Shared types and constants for the HDMI transmit video guard:
//   - lock_state_t : geometry lock state machine encoding
//   - H_ACTIVE_720P / V_ACTIVE_720P : 1280x720 active geometry
//   - rgb24_t      : packed 24-bit {R,G,B} pixel
//   - BAR_COLORS   : 8 vertical colour bars, left to right
// -----------------------------------------------------------------------------
package hdmi_video_pkg;

  localparam int H_ACTIVE_720P = 1280;
  localparam int V_ACTIVE_720P = 720;

  typedef logic [23:0] rgb24_t;

  typedef enum logic [0:0] {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } lock_state_t;

  // White, yellow, cyan, green, magenta, red, blue, black
  localparam rgb24_t BAR_COLORS [8] = '{
    24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
    24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
  };

endpackage

// File: rtl/hdmi_colorbar_gen.sv
// -----------------------------------------------------------------------------
// hdmi_colorbar_gen
// Generates 8 vertical colour bars of BAR_W pixels each, restarting at every
// line start. The bar position is tracked with a pixel-in-bar counter and a
// saturating bar index, so no divider is needed.
// Ports:
//   pixel_clk   in   video clock
//   reset_n     in   asynchronous active-low reset
//   de          in   data enable of the pixel being generated
//   line_start  in   strobe, high on the first DE-high pixel of a line
//   bar_rgb     out  registered bar colour (0 while DE is low)
// -----------------------------------------------------------------------------
module hdmi_colorbar_gen
  import hdmi_video_pkg::*;
#(
  parameter int BAR_W = 160
) (
  input  logic   pixel_clk,
  input  logic   reset_n,
  input  logic   de,
  input  logic   line_start,
  output rgb24_t bar_rgb
);

  localparam int PXW = (BAR_W > 1) ? $clog2(BAR_W) : 1;

  logic [PXW-1:0] bar_px_r;
  logic [PXW-1:0] cur_px_s;
  logic [PXW-1:0] px_nxt_s;
  logic [2:0]     bar_idx_r;
  logic [2:0]     cur_idx_s;
  logic [2:0]     idx_nxt_s;

  // Position of the current pixel and of the one after it
  always_comb begin
    cur_px_s  = bar_px_r;
    cur_idx_s = bar_idx_r;
    px_nxt_s  = bar_px_r;
    idx_nxt_s = bar_idx_r;
    if (line_start) begin
      cur_px_s  = '0;
      cur_idx_s = 3'd0;
    end else begin
      cur_px_s  = bar_px_r;
      cur_idx_s = bar_idx_r;
    end
    if (de) begin
      if (cur_px_s == PXW'(BAR_W - 1)) begin
        px_nxt_s  = '0;
        idx_nxt_s = (cur_idx_s == 3'd7) ? 3'd7 : cur_idx_s + 3'd1;
      end else begin
        px_nxt_s  = cur_px_s + PXW'(1);
        idx_nxt_s = cur_idx_s;
      end
    end else begin
      px_nxt_s  = bar_px_r;
      idx_nxt_s = bar_idx_r;
    end
  end

  // Bar counters and registered colour output
  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      bar_px_r  <= '0;
      bar_idx_r <= 3'd0;
      bar_rgb   <= 24'h000000;
    end else begin
      bar_px_r  <= px_nxt_s;
      bar_idx_r <= idx_nxt_s;
      bar_rgb   <= de ? BAR_COLORS[cur_idx_s] : 24'h000000;
    end
  end

endmodule

// File: rtl/hdmi_tx_video_guard.sv
// -----------------------------------------------------------------------------
// hdmi_tx_video_guard
// Sits between the HDMI formatter and the ADV7513 pins. Measures every frame
// against the expected active geometry, locks after LOCK_FRAMES consecutive
// good frames, and substitutes colour bars while unlocked or when forced.
// Two-stage pipeline: stage 1 registers inputs, detects edges, measures and
// generates bars; stage 2 is the output mux. Syncs/DE always pass through.
// Ports:
//   pixel_clk, reset_n                 clock, async active-low reset
//   vid_de_i, vid_hsync_i, vid_vsync_i upstream DE and active-low syncs
//   vid_r_i, vid_g_i, vid_b_i          upstream pixel
//   force_pattern_i                    async quasi-static bar request
//   data_enable, hsync, vsync          DE/syncs to ADV7513
//   data_r, data_g, data_b             pixel to ADV7513
//   locked_o                           geometry lock status
//   pattern_active_o                   colour bars substituted
//   bad_frame_cnt_o                    saturating bad-frame/timeout count
// -----------------------------------------------------------------------------
module hdmi_tx_video_guard
  import hdmi_video_pkg::*;
#(
  parameter int H_ACTIVE    = H_ACTIVE_720P,
  parameter int V_ACTIVE    = V_ACTIVE_720P,
  parameter int LOCK_FRAMES = 4,
  parameter int TIMEOUT_CYC = 2000000,
  parameter int BAR_W       = H_ACTIVE / 8
) (
  input  logic        pixel_clk,
  input  logic        reset_n,
  input  logic        vid_de_i,
  input  logic        vid_hsync_i,
  input  logic        vid_vsync_i,
  input  logic [7:0]  vid_r_i,
  input  logic [7:0]  vid_g_i,
  input  logic [7:0]  vid_b_i,
  input  logic        force_pattern_i,
  output logic        data_enable,
  output logic        hsync,
  output logic        vsync,
  output logic [7:0]  data_r,
  output logic [7:0]  data_g,
  output logic [7:0]  data_b,
  output logic        locked_o,
  output logic        pattern_active_o,
  output logic [15:0] bad_frame_cnt_o
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic        force_meta_r;
  logic        force_sync_r;
  logic        de_r;
  logic        hs_r;
  logic        vs_r;
  logic        de_d_r;
  logic        vs_d_r;
  rgb24_t      rgb_in_r;
  rgb24_t      bar_rgb_s;
  logic        cb_line_start_s;
  logic        line_start_s;
  logic        line_end_s;
  logic        frame_bnd_s;
  logic [11:0] pix_cnt_r;
  logic [10:0] line_cnt_r;
  logic [10:0] line_cnt_eff_s;
  logic        line_err_r;
  logic        line_err_eff_s;
  logic        frame_good_s;
  logic [TW-1:0] timer_r;
  logic        timeout_s;
  lock_state_t state_r;
  lock_state_t state_nxt_s;
  logic [3:0]  good_cnt_r;
  logic [3:0]  good_cnt_nxt_s;
  logic        armed_r;
  logic        armed_nxt_s;
  logic        bad_inc_s;

  // Stage-1 edge events
  assign line_start_s = de_r & ~de_d_r;
  assign line_end_s   = ~de_r & de_d_r;
  assign frame_bnd_s  = ~vs_r & vs_d_r;
  // Bar generator works on the raw input so its registered colour lines up
  // with the stage-1 pixel registers.
  assign cb_line_start_s = vid_de_i & ~de_r;
  assign timeout_s = ~frame_bnd_s && (timer_r == TW'(TIMEOUT_CYC - 1));

  hdmi_colorbar_gen #(
    .BAR_W (BAR_W)
  ) u_colorbar (
    .pixel_clk  (pixel_clk),
    .reset_n    (reset_n),
    .de         (vid_de_i),
    .line_start (cb_line_start_s),
    .bar_rgb    (bar_rgb_s)
  );

  // Two-flop synchroniser for the asynchronous pattern request
  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      force_meta_r <= 1'b0;
      force_sync_r <= 1'b0;
    end else begin
      force_meta_r <= force_pattern_i;
      force_sync_r <= force_meta_r;
    end
  end

  // Stage-1 input registers and edge-detect delays
  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      de_r     <= 1'b0;
      hs_r     <= 1'b1;
      vs_r     <= 1'b1;
      de_d_r   <= 1'b0;
      vs_d_r   <= 1'b1;
      rgb_in_r <= 24'h000000;
    end else begin
      de_r     <= vid_de_i;
      hs_r     <= vid_hsync_i;
      vs_r     <= vid_vsync_i;
      de_d_r   <= de_r;
      vs_d_r   <= vs_r;
      rgb_in_r <= {vid_r_i, vid_g_i, vid_b_i};
    end
  end

  // Fold a line ending in this cycle into the frame totals before judging
  always_comb begin
    line_cnt_eff_s = line_cnt_r;
    line_err_eff_s = line_err_r;
    if (line_end_s) begin
      line_cnt_eff_s = (line_cnt_r == 11'h7FF) ? 11'h7FF : line_cnt_r + 11'd1;
      line_err_eff_s = line_err_r | (pix_cnt_r != 12'(H_ACTIVE));
    end else begin
      line_cnt_eff_s = line_cnt_r;
      line_err_eff_s = line_err_r;
    end
    frame_good_s = ~line_err_eff_s && (line_cnt_eff_s == 11'(V_ACTIVE));
  end

  // Pixel and line measurement counters
  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      pix_cnt_r  <= 12'd0;
      line_cnt_r <= 11'd0;
      line_err_r <= 1'b0;
    end else begin
      if (line_start_s) begin
        pix_cnt_r <= 12'd1;
      end else if (de_r && pix_cnt_r != 12'hFFF) begin
        pix_cnt_r <= pix_cnt_r + 12'd1;
      end
      if (frame_bnd_s) begin
        line_cnt_r <= 11'd0;
        line_err_r <= 1'b0;
      end else begin
        line_cnt_r <= line_cnt_eff_s;
        line_err_r <= line_err_eff_s;
      end
    end
  end

  // Cycles since the last frame boundary
  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      timer_r <= '0;
    end else if (frame_bnd_s || timeout_s) begin
      timer_r <= '0;
    end else begin
      timer_r <= timer_r + TW'(1);
    end
  end

  // Lock state machine: next state, good-frame count, arming
  always_comb begin
    state_nxt_s    = state_r;
    good_cnt_nxt_s = good_cnt_r;
    armed_nxt_s    = armed_r;
    bad_inc_s      = 1'b0;
    if (timeout_s) begin
      state_nxt_s    = UNLOCKED;
      good_cnt_nxt_s = 4'd0;
      armed_nxt_s    = 1'b0;
      bad_inc_s      = 1'b1;
    end else if (frame_bnd_s) begin
      if (!armed_r) begin
        // First boundary only closes the partial frame
        armed_nxt_s = 1'b1;
      end else begin
        case (state_r)
          UNLOCKED: begin
            if (frame_good_s) begin
              good_cnt_nxt_s = good_cnt_r + 4'd1;
              state_nxt_s    = (good_cnt_r + 4'd1 == 4'(LOCK_FRAMES)) ? LOCKED : UNLOCKED;
            end else begin
              good_cnt_nxt_s = 4'd0;
              bad_inc_s      = 1'b1;
            end
          end
          LOCKED: begin
            if (frame_good_s) begin
              state_nxt_s = LOCKED;
            end else begin
              state_nxt_s    = UNLOCKED;
              good_cnt_nxt_s = 4'd0;
              bad_inc_s      = 1'b1;
            end
          end
          default: begin
            state_nxt_s    = UNLOCKED;
            good_cnt_nxt_s = 4'd0;
          end
        endcase
      end
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Lock state registers and status outputs
  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r          <= UNLOCKED;
      good_cnt_r       <= 4'd0;
      armed_r          <= 1'b0;
      locked_o         <= 1'b0;
      pattern_active_o <= 1'b1;
      bad_frame_cnt_o  <= 16'd0;
    end else begin
      state_r    <= state_nxt_s;
      good_cnt_r <= good_cnt_nxt_s;
      armed_r    <= armed_nxt_s;
      locked_o   <= (state_nxt_s == LOCKED);
      // Pattern choice only moves at a frame boundary: no mid-frame switch
      if (frame_bnd_s) begin
        pattern_active_o <= (state_nxt_s != LOCKED) || force_sync_r;
      end
      if (bad_inc_s && bad_frame_cnt_o != 16'hFFFF) begin
        bad_frame_cnt_o <= bad_frame_cnt_o + 16'd1;
      end
    end
  end

  // Stage-2 output mux
  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      data_enable <= 1'b0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      data_r      <= 8'd0;
      data_g      <= 8'd0;
      data_b      <= 8'd0;
    end else begin
      data_enable <= de_r;
      hsync       <= hs_r;
      vsync       <= vs_r;
      {data_r, data_g, data_b} <= pattern_active_o ? bar_rgb_s : rgb_in_r;
    end
  end

endmodule

// File: tb/tb_hdmi_tx_video_guard.sv
// -----------------------------------------------------------------------------
// tb_hdmi_tx_video_guard
// Directed bench for hdmi_tx_video_guard on a scaled geometry (16x4 active,
// bars 2 pixels wide, timeout 200 cycles). Every cycle the outputs are held
// against the inputs of two cycles earlier (bars when the pattern is
// expected); lock status and bad-frame count are checked after each boundary.
// -----------------------------------------------------------------------------
module tb_hdmi_tx_video_guard;

  localparam int H  = 16;
  localparam int V  = 4;
  localparam int LF = 4;
  localparam int TO = 200;
  localparam int BW = 2;

  logic        pixel_clk = 1'b0;
  logic        reset_n;
  logic        vid_de_i, vid_hsync_i, vid_vsync_i;
  logic [7:0]  vid_r_i, vid_g_i, vid_b_i;
  logic        force_pattern_i;
  logic        data_enable, hsync, vsync;
  logic [7:0]  data_r, data_g, data_b;
  logic        locked_o, pattern_active_o;
  logic [15:0] bad_frame_cnt_o;

  int total = 0;
  int bad   = 0;

  logic        last_de, last_hs, last_vs;
  logic [23:0] last_rgb;
  int          last_x;
  logic        cur_pat;

  logic [23:0] bar_tbl [0:7] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                 24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  hdmi_tx_video_guard #(
    .H_ACTIVE (H), .V_ACTIVE (V), .LOCK_FRAMES (LF), .TIMEOUT_CYC (TO), .BAR_W (BW)
  ) dut (
    .pixel_clk (pixel_clk), .reset_n (reset_n),
    .vid_de_i (vid_de_i), .vid_hsync_i (vid_hsync_i), .vid_vsync_i (vid_vsync_i),
    .vid_r_i (vid_r_i), .vid_g_i (vid_g_i), .vid_b_i (vid_b_i),
    .force_pattern_i (force_pattern_i),
    .data_enable (data_enable), .hsync (hsync), .vsync (vsync),
    .data_r (data_r), .data_g (data_g), .data_b (data_b),
    .locked_o (locked_o), .pattern_active_o (pattern_active_o),
    .bad_frame_cnt_o (bad_frame_cnt_o)
  );

  always #5 pixel_clk = ~pixel_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic reset_model();
    last_de  = 1'b0;
    last_hs  = 1'b1;
    last_vs  = 1'b1;
    last_rgb = 24'h000000;
    last_x   = 0;
    cur_pat  = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_de"},   {31'd0, data_enable}, 32'd0);
    check({tag, "_hs"},   {31'd0, hsync}, 32'd1);
    check({tag, "_vs"},   {31'd0, vsync}, 32'd1);
    check({tag, "_rgb"},  {8'd0, data_r, data_g, data_b}, 32'd0);
    check({tag, "_lock"}, {31'd0, locked_o}, 32'd0);
    check({tag, "_pat"},  {31'd0, pattern_active_o}, 32'd1);
    check({tag, "_bad"},  {16'd0, bad_frame_cnt_o}, 32'd0);
  endtask

  // One pixel clock: drive inputs, then check the output of two cycles back
  task automatic tick(input logic de, input logic hs, input logic vs,
                      input logic [23:0] rgb, input int x);
    logic [23:0] exp_rgb;
    int idx;
    vid_de_i = de;
    vid_hsync_i = hs;
    vid_vsync_i = vs;
    {vid_r_i, vid_g_i, vid_b_i} = rgb;
    @(posedge pixel_clk);
    #1;
    check("sync_pass", {29'd0, data_enable, hsync, vsync}, {29'd0, last_de, last_hs, last_vs});
    idx = last_x / BW;
    if (idx > 7) idx = 7;
    if (!last_de) exp_rgb = 24'h000000;
    else if (cur_pat) exp_rgb = bar_tbl[idx];
    else exp_rgb = last_rgb;
    check(cur_pat ? "rgb_bars" : "rgb_pass", {8'd0, data_r, data_g, data_b}, {8'd0, exp_rgb});
    last_de = de;
    last_hs = hs;
    last_vs = vs;
    last_rgb = rgb;
    last_x = x;
  endtask

  task automatic send_line(input int len);
    for (int x = 0; x < len; x++) tick(1'b1, 1'b1, 1'b1, 24'($urandom), x);
    for (int b = 0; b < 6; b++) tick(1'b0, (b < 2) ? 1'b0 : 1'b1, 1'b1, 24'h0, 0);
  endtask

  task automatic frame_head(input logic pat, input logic lock, input int badc);
    cur_pat = pat;
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b1, 1'b0, 24'h0, 0);
    check("locked", {31'd0, locked_o}, {31'd0, lock});
    check("pattern", {31'd0, pattern_active_o}, {31'd0, pat});
    check("bad_cnt", {16'd0, bad_frame_cnt_o}, badc);
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b1, 1'b1, 24'h0, 0);
  endtask

  task automatic frame_body(input int nl, input int short_line, input int short_len);
    for (int l = 0; l < nl; l++) send_line((l == short_line) ? short_len : H);
  endtask

  task automatic frame(input int nl, input int short_line, input int short_len,
                       input logic pat, input logic lock, input int badc);
    frame_head(pat, lock, badc);
    frame_body(nl, short_line, short_len);
  endtask

  initial begin
    reset_n = 1'b0;
    force_pattern_i = 1'b0;
    vid_de_i = 1'b1; vid_hsync_i = 1'b0; vid_vsync_i = 1'b0;
    {vid_r_i, vid_g_i, vid_b_i} = 24'hABCDEF;
    repeat (3) @(posedge pixel_clk);
    #1;
    check_reset_outputs("por");
    vid_de_i = 1'b0; vid_hsync_i = 1'b1; vid_vsync_i = 1'b1;
    {vid_r_i, vid_g_i, vid_b_i} = 24'h0;
    reset_n = 1'b1;
    reset_model();

    // Arming boundary plus four good frames, lock at the fifth boundary
    for (int f = 1; f <= 4; f++) frame(V, -1, 0, 1'b1, 1'b0, 0);
    frame(V, -1, 0, 1'b0, 1'b1, 0);
    frame(V, -1, 0, 1'b0, 1'b1, 0);

    // Short line while locked, then bars and relock
    frame(V, 1, H - 1, 1'b0, 1'b1, 0);
    frame(V, -1, 0, 1'b1, 1'b0, 1);
    for (int f = 0; f < 3; f++) frame(V, -1, 0, 1'b1, 1'b0, 1);
    frame(V, -1, 0, 1'b0, 1'b1, 1);

    // One line short of a frame, then relock
    frame(V - 1, -1, 0, 1'b0, 1'b1, 1);
    frame(V, -1, 0, 1'b1, 1'b0, 2);
    for (int f = 0; f < 3; f++) frame(V, -1, 0, 1'b1, 1'b0, 2);
    frame(V, -1, 0, 1'b0, 1'b1, 2);

    // Force request mid-frame: no change until the next boundary
    frame_head(1'b0, 1'b1, 2);
    send_line(H);
    force_pattern_i = 1'b1;
    frame_body(V - 1, -1, 0);
    frame_head(1'b1, 1'b1, 2);
    send_line(H);
    force_pattern_i = 1'b0;
    frame_body(V - 1, -1, 0);
    frame(V, -1, 0, 1'b0, 1'b1, 2);

    // Syncs stop: lock holds until the timeout, then drops once
    for (int i = 0; i < 50; i++) tick(1'b0, 1'b1, 1'b1, 24'h0, 0);
    check("pre_timeout_lock", {31'd0, locked_o}, 32'd1);
    check("pre_timeout_bad", {16'd0, bad_frame_cnt_o}, 32'd2);
    for (int i = 0; i < 200; i++) tick(1'b0, 1'b1, 1'b1, 24'h0, 0);
    check("timeout_lock", {31'd0, locked_o}, 32'd0);
    check("timeout_bad", {16'd0, bad_frame_cnt_o}, 32'd3);
    for (int f = 0; f < 4; f++) frame(V, -1, 0, 1'b1, 1'b0, 3);
    frame(V, -1, 0, 1'b0, 1'b1, 3);

    // Reset in the middle of a line
    frame_head(1'b0, 1'b1, 3);
    send_line(H);
    for (int x = 0; x < 5; x++) tick(1'b1, 1'b1, 1'b1, 24'($urandom), x);
    reset_n = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    vid_de_i = 1'b0; vid_hsync_i = 1'b1; vid_vsync_i = 1'b1;
    {vid_r_i, vid_g_i, vid_b_i} = 24'h0;
    repeat (2) @(posedge pixel_clk);
    #1;
    reset_n = 1'b1;
    reset_model();
    frame_body(2, -1, 0);
    for (int f = 0; f < 4; f++) frame(V, -1, 0, 1'b1, 1'b0, 0);
    frame(V, -1, 0, 1'b0, 1'b1, 0);
    frame_head(1'b0, 1'b1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
